module_multiplier: RTL and testbench
====================================

MODULE_MULTIPLIER -- requirements
Module: module_multiplier

Interface
REQ-001 SHALL have: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-low (sampled only on rising clk edge).
REQ-003 SHALL have: numero1  input  8  unsigned binary operand A from the digit-assembly stage.
REQ-004 SHALL have: numero2  input  8  unsigned binary operand B from the digit-assembly stage.
REQ-005 SHALL have: valid  input  1  operands-ready level from upstream; may stay high for many cycles.
REQ-006 SHALL have: producto  output  16  unsigned product A*B, registered.
REQ-007 SHALL have: done  output  1  one-cycle pulse, producto newly valid.
REQ-008 SHALL have: busy  output  1  high while a multiplication is in progress.
REQ-009 SHALL have: err  output  1  range-error pulse (present only with RANGE_CHECK_EN, see Configuration).

Function
REQ-010 SHALL register valid into valid_d each cycle; start = valid & ~valid_d & (state==IDLE).
REQ-011 SHALL implement states IDLE, CALC, DONE; reset state IDLE.
REQ-012 SHALL, on start edge: capture A into multiplicand reg (16-bit, zero-extended), B into multiplier reg, clear accumulator, clear 3-bit iteration counter, go to CALC, busy=1.
REQ-013 SHALL, each CALC edge: if multiplier LSB=1 add multiplicand to accumulator (16-bit, no overflow possible); shift multiplicand left 1, multiplier right 1; counter+1.
REQ-014 SHALL leave CALC after exactly 8 iterations (counter wraps 7->0), loading producto from final accumulator, going to DONE.
REQ-015 SHALL assert done=1 for exactly the one cycle in DONE; busy=0 in DONE; next edge -> IDLE.
REQ-016 Latency: start sampled at edge k -> done high during the cycle after edge k+8; producto stable from that cycle.
REQ-017 SHALL hold producto unchanged until the next DONE update (not cleared in IDLE or CALC).
REQ-018 SHALL ignore valid rising edges while busy or in DONE; such edges are lost, not queued.
REQ-019 SHALL not restart while valid stays high after completion; a new start requires valid low for >=1 cycle then high.
REQ-020 SHALL produce A*B exactly for all A,B in 0..255; zero operand yields producto=0 with normal latency.
REQ-021 Operand inputs SHALL be don't-care outside the capture edge.

Reset
REQ-022 SHALL, when rst=0 at a rising edge: state=IDLE, producto=0, done=0, busy=0, err=0, valid_d=0, internal regs=0.
REQ-023 Reset mid-CALC SHALL abort the operation with no done pulse; producto=0.
REQ-024 If valid is high on the first edge after rst release, SHALL treat it as a start (valid_d cleared by reset).

Configuration
REQ-025 Macro RANGE_CHECK_EN: when defined, start with numero1>99 or numero2>99 SHALL skip CALC, assert err for one cycle (next cycle), leave producto unchanged, no done, return to IDLE.
REQ-026 With RANGE_CHECK_EN undefined, err SHALL be tied 0 and all operands 0..255 multiplied normally.

Verification
REQ-027 Reset: hold rst=0 2 cycles -> producto=0x0000, done=0, busy=0, err=0.
REQ-028 Basic: A=12, B=34, valid 0->1 -> busy 8 cycles, done pulse 1 cycle, producto=408 (0x0198), 9 edges after capture.
REQ-029 Corners: A=99,B=99 -> 9801 (0x2649); A=0,B=57 -> 0; A=255,B=255 -> 65025 (0xFE01, no RANGE_CHECK_EN).
REQ-030 Held valid: valid high 30 cycles with A=7,B=8 -> exactly one done, producto=56; drop and re-raise -> second done.
REQ-031 Reset mid-op: start A=50,B=50, rst=0 at 4th CALC cycle -> no done, producto=0, IDLE; subsequent start computes 2500.
REQ-032 RANGE_CHECK_EN: A=100,B=3 -> err pulse 1 cycle, no done, producto keeps prior 408.

Source files
------------

// File: rtl/module_multiplier.sv
// Sequential 8x8 shift-and-add multiplier: one iteration per clock, 16-bit registered product.
// Optional operand range check (0..99) enabled by defining RANGE_CHECK_EN.
module module_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  numero1,
  input  logic [7:0]  numero2,
  input  logic        valid,
  output logic [15:0] producto,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        valid_d;
  logic [15:0] mcand;
  logic [15:0] acc;
  logic [7:0]  mplier;
  logic [2:0]  cnt;
  logic        start;
  logic        range_bad;
  logic [15:0] acc_sum;

  // Only a fresh rising edge of valid seen from IDLE starts an operation.
  assign start = valid & ~valid_d & (state == IDLE);

`ifdef RANGE_CHECK_EN
  assign range_bad = (numero1 > 8'd99) | (numero2 > 8'd99);
`else
  assign range_bad = 1'b0;
`endif

  assign acc_sum   = mplier[0] ? (acc + mcand) : acc;
  assign busy      = (state == CALC);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !range_bad) state_nxt = CALC;
      CALC:    if (cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      valid_d  <= 1'b0;
      mcand    <= 16'd0;
      mplier   <= 8'd0;
      acc      <= 16'd0;
      cnt      <= 3'd0;
      producto <= 16'd0;
    end else begin
      valid_d <= valid;
      state   <= state_nxt;
      case (state)
        IDLE: begin
          if (start && !range_bad) begin
            mcand  <= {8'd0, numero1};
            mplier <= numero2;
            acc    <= 16'd0;
            cnt    <= 3'd0;
          end
        end
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
          // Last iteration: publish the sum including this cycle's partial product.
          if (cnt == 3'd7) producto <= acc_sum;
        end
        default: ;
      endcase
    end
  end

`ifdef RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst) err <= 1'b0;
    else      err <= start & range_bad;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_module_multiplier.sv
// Scoreboard bench for module_multiplier: driver pushes expected products and done times,
// a negedge monitor pops and compares whenever done is presented.
module tb_module_multiplier;

  logic        clk;
  logic        rst;
  logic [7:0]  numero1;
  logic [7:0]  numero2;
  logic        valid;
  logic [15:0] producto;
  logic        done;
  logic        busy;
  logic        err;
  logic [1:0]  dbg_state;

  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          busy_run = 0;
  int          err_cnt = 0;
  int          exp_err = 0;

  module_multiplier dut (
    .clk      (clk),
    .rst      (rst),
    .numero1  (numero1),
    .numero2  (numero2),
    .valid    (valid),
    .producto (producto),
    .done     (done),
    .busy     (busy),
    .err      (err),
    .dbg_state(dbg_state)
  );

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Monitor: product, latency and busy-length checks on every done pulse
  always @(negedge clk) begin
    if (err) err_cnt++;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(producto), 32'hFFFF_FFFF);
      end else begin
        check("producto", 32'(producto), 32'(exp_q.pop_front()));
        check("latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        check("busy_cycles", 32'(busy_run), 32'd8);
        check("busy_in_done", 32'(busy), 32'd0);
      end
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  // Driver tasks
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    wait_idle();
    valid   = 1'b0;
    numero1 = a;
    numero2 = b;
    @(negedge clk);
    valid = 1'b1;
    exp_q.push_back(16'(a) * 16'(b));
    exp_cyc_q.push_back(cyc + 9);
    @(negedge clk);
    // Operands are don't-care once captured.
    numero1 = 8'($urandom);
    numero2 = 8'($urandom);
    valid   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    int         done_seen;
    rst     = 1'b0;
    valid   = 1'b0;
    numero1 = 8'd0;
    numero2 = 8'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_producto", 32'(producto), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic and corner products
    issue(8'd12, 8'd34);
    drain();
    check("basic_hold", 32'(producto), 32'd408);

`ifdef RANGE_CHECK_EN
    // Out-of-range start: err pulse, no done, product retained
    wait_idle();
    numero1 = 8'd100;
    numero2 = 8'd3;
    @(negedge clk);
    valid = 1'b1;
    exp_err = 1;
    @(negedge clk);
    check("range_err_pulse", 32'(err), 32'd1);
    check("range_no_busy", 32'(busy), 32'd0);
    valid = 1'b0;
    @(negedge clk);
    check("range_err_clear", 32'(err), 32'd0);
    repeat (10) @(negedge clk);
    check("range_producto_kept", 32'(producto), 32'd408);
`endif

    issue(8'd99, 8'd99);
    issue(8'd0, 8'd57);
    issue(8'd57, 8'd0);
`ifndef RANGE_CHECK_EN
    issue(8'd255, 8'd255);
    issue(8'd255, 8'd1);
`endif
    drain();

    // Held valid: exactly one done, then drop and re-raise for a second
    wait_idle();
    numero1 = 8'd7;
    numero2 = 8'd8;
    @(negedge clk);
    valid = 1'b1;
    exp_q.push_back(16'd56);
    exp_cyc_q.push_back(cyc + 9);
    repeat (30) @(negedge clk);
    check("held_one_done", 32'(exp_q.size()), 32'd0);
    check("held_producto", 32'(producto), 32'd56);
    valid = 1'b0;
    issue(8'd7, 8'd8);
    drain();

    // Rising edges during busy are lost
    issue(8'd20, 8'd30);
    repeat (2) @(negedge clk);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    valid = 1'b1;
    repeat (15) @(negedge clk);
    valid = 1'b0;
    check("lost_edges_queue", 32'(exp_q.size()), 32'd0);
    check("lost_edges_producto", 32'(producto), 32'd600);

    // Reset during CALC aborts; valid high at release starts immediately
    wait_idle();
    numero1 = 8'd50;
    numero2 = 8'd50;
    @(negedge clk);
    valid = 1'b1;
    repeat (4) @(negedge clk);
    valid = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("abort_producto", 32'(producto), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_state_idle", 32'(dbg_state), 32'd0);
    valid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(16'd2500);
    exp_cyc_q.push_back(cyc + 9);
    @(negedge clk);
    valid = 1'b0;
    drain();

    // Randomized operands against plain multiplication
    for (int i = 0; i < 20; i++) begin
`ifdef RANGE_CHECK_EN
      a = 8'($urandom_range(0, 99));
      b = 8'($urandom_range(0, 99));
`else
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
`endif
      issue(a, b);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    drain();

    // No stray done after everything settles
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("quiet_done", 32'(done_seen), 32'd0);
    check("err_pulses", 32'(err_cnt), 32'(exp_err));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
